// File: rtl/s_to_u_pipe_pkg.sv
// Shared FPU definitions for the signed-to-sign/magnitude converter.
// Holds the mode encoding, the default fraction width and most-negative detection.
package s_to_u_pipe_pkg;

  typedef enum logic [1:0] {
    S2U_MAG   = 2'd0,
    S2U_SHIFT = 2'd1,
    S2U_NORM  = 2'd2,
    S2U_RSVD  = 2'd3
  } s2u_mode_t;

  localparam int S2U_FRAC_W = 27;

  // True when the low w bits of v hold the most-negative two's-complement value
  // (the upper bits of v are expected to be zero).
  function automatic logic s2u_is_most_neg(input logic [63:0] v, input int unsigned w);
    return v == (64'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/lzc_pow2.sv
// Combinational leading-zero counter with zero flag.
// An all-zero input reports a count equal to the input width.
module lzc_pow2 #(
  parameter int MAG_W = 26,
  parameter int LZC_W = 5
) (
  input  logic [MAG_W-1:0] i_val,
  output logic [LZC_W-1:0] o_lzc,
  output logic             o_zero
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    o_lzc = LZC_W'(MAG_W);
    for (int i = 0; i < MAG_W; i++)
      if (i_val[i]) o_lzc = LZC_W'(MAG_W - 1 - i);
  end

  assign o_zero = ~|i_val;

endmodule

// File: rtl/s_to_u_pipe.sv
// Two-stage signed-to-sign/magnitude converter with valid/ready on both sides.
// Stage A forms sign and magnitude; stage B counts leading zeros and normalises.
module s_to_u_pipe
  import s_to_u_pipe_pkg::*;
#(
  parameter  int FRAC_W = S2U_FRAC_W,
  parameter  int TAG_W  = 4,
  localparam int MAG_W  = FRAC_W - 1,
  localparam int LZC_W  = $clog2(FRAC_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MAG_W-1:0]  out_mag,
  output logic [LZC_W-1:0]  out_lzc,
  output logic              out_zero,
  output logic              out_ovf,
  output logic [TAG_W-1:0]  out_tag
);

  // [0] = stage A, [1] = stage B
  logic [1:0]       r_vld_pipe;

  logic             r_a_sign, r_a_ovf;
  logic [MAG_W-1:0] r_a_mag;
  s2u_mode_t        r_a_mode;
  logic [TAG_W-1:0] r_a_tag;

  logic             r_b_sign, r_b_ovf, r_b_zero;
  logic [MAG_W-1:0] r_b_mag;
  logic [LZC_W-1:0] r_b_lzc;
  logic [TAG_W-1:0] r_b_tag;

  logic             w_rdy_a, w_rdy_b, w_acc, w_adv;
  s2u_mode_t        w_mode;
  logic             w_most_neg, w_a_ovf;
  logic [MAG_W-1:0] w_a_mag, w_b_mag, w_norm;
  logic [LZC_W-1:0] w_lzc;
  logic             w_zero;

  assign w_rdy_b  = !r_vld_pipe[1] | out_ready;
  assign w_rdy_a  = !r_vld_pipe[0] | w_rdy_b;
  assign in_ready = w_rdy_a;
  assign w_acc    = in_valid & w_rdy_a;
  assign w_adv    = r_vld_pipe[0] & w_rdy_b;

  assign w_mode     = s2u_mode_t'(in_mode);
  assign w_most_neg = s2u_is_most_neg(64'(in_frac), FRAC_W);

  // Most-negative input saturates instead of wrapping its magnitude to zero.
  always_comb begin
    w_a_mag = in_frac[MAG_W-1:0];
    w_a_ovf = 1'b0;
    if (w_mode == S2U_SHIFT)
      w_a_mag = {in_frac[FRAC_W-3:0], 1'b0};
    else if (w_most_neg) begin
      w_a_mag = '1;
      w_a_ovf = 1'b1;
    end else if (in_frac[FRAC_W-1])
      w_a_mag = -in_frac[MAG_W-1:0];
  end

  lzc_pow2 #(.MAG_W(MAG_W), .LZC_W(LZC_W)) u_lzc (
    .i_val  (r_a_mag),
    .o_lzc  (w_lzc),
    .o_zero (w_zero)
  );

  assign w_norm  = r_a_mag << w_lzc;
  assign w_b_mag = (r_a_mode == S2U_NORM) ? w_norm : r_a_mag;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld_pipe <= '0;
      r_a_sign   <= 1'b0;
      r_a_ovf    <= 1'b0;
      r_a_mag    <= '0;
      r_a_mode   <= S2U_MAG;
      r_a_tag    <= '0;
      r_b_sign   <= 1'b0;
      r_b_ovf    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_b_mag    <= '0;
      r_b_lzc    <= '0;
      r_b_tag    <= '0;
    end else begin
      if (flush)
        r_vld_pipe <= '0;
      else begin
        if (w_rdy_a) r_vld_pipe[0] <= in_valid;
        if (w_rdy_b) r_vld_pipe[1] <= r_vld_pipe[0];
      end
      if (w_acc) begin
        r_a_sign <= in_frac[FRAC_W-1];
        r_a_ovf  <= w_a_ovf;
        r_a_mag  <= w_a_mag;
        r_a_mode <= w_mode;
        r_a_tag  <= in_tag;
      end
      if (w_adv) begin
        r_b_sign <= r_a_sign;
        r_b_ovf  <= r_a_ovf;
        r_b_zero <= w_zero;
        r_b_mag  <= w_b_mag;
        r_b_lzc  <= w_lzc;
        r_b_tag  <= r_a_tag;
      end
    end
  end

  assign out_valid = r_vld_pipe[1];
  assign out_sign  = r_b_sign;
  assign out_mag   = r_b_mag;
  assign out_lzc   = r_b_lzc;
  assign out_zero  = r_b_zero;
  assign out_ovf   = r_b_ovf;
  assign out_tag   = r_b_tag;

endmodule

// File: tb/tb_s_to_u_pipe.sv
// Self-checking bench for s_to_u_pipe: directed vectors, stalls, reset, flush
// and randomized traffic against an arithmetic reference model.
module tb_s_to_u_pipe;

  localparam int FW = 27;
  localparam int MW = 26;
  localparam int LW = 5;
  localparam int TW = 4;

  logic          CLK = 1'b0;
  logic          RST, flush, in_valid, in_ready, out_valid, out_ready;
  logic [FW-1:0] in_frac;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_sign, out_zero, out_ovf;
  logic [MW-1:0] out_mag;
  logic [LW-1:0] out_lzc;

  always #5 CLK = ~CLK;

  s_to_u_pipe #(.FRAC_W(FW), .TAG_W(TW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_frac(in_frac),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mag(out_mag), .out_lzc(out_lzc), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_tag(out_tag)
  );

  typedef struct packed {
    logic          sign;
    logic [MW-1:0] mag;
    logic [LW-1:0] lzc;
    logic          zero;
    logic          ovf;
    logic [TW-1:0] tag;
  } item_t;

  item_t exp_q[$], exp_done[$], got_q[$];
  int    total = 0, bad = 0, stab_err = 0, sp_err = 0;
  logic  prev_stall = 1'b0;
  item_t prev_out;

  function automatic item_t model(input logic [FW-1:0] f, input logic [1:0] md,
                                  input logic [TW-1:0] tg);
    item_t  r;
    longint v, a;
    int     len;
    v = longint'(f);
    if (f[FW-1]) v = v - (longint'(1) <<< FW);
    r.sign = f[FW-1];
    r.ovf  = 1'b0;
    if (md == 2'd1)
      a = (longint'(f) * 2) % (longint'(1) <<< MW);
    else begin
      a = (v < 0) ? -v : v;
      if (a == (longint'(1) <<< MW)) begin
        a     = a - 1;
        r.ovf = 1'b1;
      end
    end
    len = 0;
    while ((a >> len) != 0) len++;
    r.lzc  = LW'(MW - len);
    r.zero = (a == 0);
    if (md == 2'd2) a = a << (MW - len);
    r.mag = MW'(a);
    r.tag = tg;
    return r;
  endfunction

  function automatic item_t cur_out();
    item_t r;
    r.sign = out_sign; r.mag = out_mag; r.lzc = out_lzc;
    r.zero = out_zero; r.ovf = out_ovf; r.tag = out_tag;
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    item_t o;
    @(negedge CLK);
    o = cur_out();
    if (prev_stall && o !== prev_out) stab_err++;
    prev_stall = out_valid && !out_ready;
    prev_out   = o;
    if (out_valid && out_ready) begin
      got_q.push_back(o);
      if (exp_q.size() > 0) exp_done.push_back(exp_q.pop_front());
      else sp_err++;
    end
    if (flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(in_frac, in_mode, in_tag));
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp_done.delete(); got_q.delete();
    stab_err = 0; sp_err = 0; prev_stall = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_frac = '0; in_mode = '0; in_tag = '0;
    #12;
    total++;
    if (out_valid !== 1'b0 || cur_out() !== '0) begin
      bad++; $display("FAIL reset_outputs: got v=%b %h expected v=0 0", out_valid, cur_out());
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [FW-1:0] vf [5] = '{27'h7FFFFFB, 27'h7FFFFFB, 27'h0, 27'h4000000, 27'h5555555};
    logic [1:0]    vm [5] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd1};
    logic          vs [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [MW-1:0] vg [5] = '{26'd5, 26'h2800000, 26'h0, 26'h3FFFFFF, 26'h2AAAAAA};
    logic [LW-1:0] vl [5] = '{5'd23, 5'd23, 5'd26, 5'd0, 5'd0};
    logic          vz [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          vo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    item_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_frac = vf[i]; in_mode = vm[i]; in_tag = TW'(i + 1); in_valid = 1'b1;
      @(negedge CLK);
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL dir%0d_latency_early: got out_valid=%b expected 0", i, out_valid);
      end
      @(posedge CLK); #1;
      @(negedge CLK);
      e.sign = vs[i]; e.mag = vg[i]; e.lzc = vl[i]; e.zero = vz[i]; e.ovf = vo[i];
      e.tag = TW'(i + 1);
      total++;
      if (out_valid !== 1'b1 || cur_out() !== e) begin
        bad++;
        $display("FAIL dir%0d_result: got v=%b %h expected v=1 %h", i, out_valid, cur_out(), e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    clear_sb();
    for (int c = 0; c < 100 && (sent < 8 || got_q.size() < 8); c++) begin
      in_valid  = (sent < 8);
      in_frac   = FW'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = TW'(sent);
      out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_backpressure_c%0d: got in_ready=%b expected 0", c, in_ready);
        end
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got_q.size() !== 8 || exp_done.size() !== 8) begin
      bad++; $display("FAIL b2b_count: got %0d expected 8", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_done.size(); i++) begin
      total++;
      if (got_q[i] !== exp_done[i]) begin
        bad++; $display("FAIL b2b_item%0d: got %h expected %h", i, got_q[i], exp_done[i]);
      end
    end
    total++;
    if (stab_err !== 0 || sp_err !== 0) begin
      bad++; $display("FAIL b2b_stable: got stab=%0d spur=%0d expected 0 0", stab_err, sp_err);
    end
  endtask

  task automatic test_random();
    int r;
    clear_sb();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      case (r)
        0:       in_frac = '0;
        1:       in_frac = 27'h4000000;
        2:       in_frac = FW'($urandom_range(0, 40)) - FW'(20);
        default: in_frac = FW'($urandom);
      endcase
      in_mode = 2'($urandom_range(0, 3));
      in_tag  = TW'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    total++;
    if (exp_q.size() !== 0 || got_q.size() !== exp_done.size() || sp_err !== 0) begin
      bad++;
      $display("FAIL rand_count: got %0d delivered, %0d pending, spur=%0d expected %0d 0 0",
               got_q.size(), exp_q.size(), sp_err, exp_done.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_done.size(); i++) begin
      total++;
      if (got_q[i] !== exp_done[i]) begin
        bad++; $display("FAIL rand_item%0d: got %h expected %h", i, got_q[i], exp_done[i]);
      end
    end
    total++;
    if (stab_err !== 0) begin
      bad++; $display("FAIL rand_stable: got %0d changes expected 0", stab_err);
    end
  endtask

  task automatic test_rst_midflight();
    clear_sb();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0;
    in_frac = 27'd7; in_tag = 4'd9; tick();
    in_frac = 27'd3; in_tag = 4'd10; tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_pre_full: got out_valid=%b expected 1", out_valid);
    end
    #2 RST = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_async: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    clear_sb();
    out_ready = 1'b1;
    repeat (6) tick();
    total++;
    if (got_q.size() !== 0) begin
      bad++; $display("FAIL rst_stale: got %0d items expected 0", got_q.size());
    end
  endtask

  task automatic test_flush();
    clear_sb();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd2;
    in_frac = 27'd11; in_tag = 4'd1; tick();
    in_frac = 27'd12; in_tag = 4'd2; tick();
    in_frac = 27'd13; in_tag = 4'd3; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_full_valid: got %b expected 0", out_valid);
    end
    out_ready = 1'b1;
    repeat (5) tick();
    total++;
    if (got_q.size() !== 0) begin
      bad++; $display("FAIL flush_full_emerge: got %0d items expected 0", got_q.size());
    end
    // Flush concurrent with an accepted transfer.
    clear_sb();
    out_ready = 1'b0; in_valid = 1'b1; in_frac = 27'd21; in_tag = 4'd4; tick();
    in_frac = 27'd22; in_tag = 4'd5; flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_concurrent_rdy: got %b expected 1", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    total++;
    if (got_q.size() !== 0) begin
      bad++; $display("FAIL flush_accept_emerge: got %0d items expected 0", got_q.size());
    end
    // Pipe recovers after flush.
    in_valid = 1'b1; in_mode = 2'd0; in_frac = 27'h7FFFFF0; in_tag = 4'd6; tick();
    in_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (got_q.size() !== 1 || exp_done.size() !== 1 || got_q[0] !== exp_done[0]) begin
      bad++; $display("FAIL flush_recover: got %0d items expected 1 matching", got_q.size());
    end
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_frac = '0; in_mode = '0; in_tag = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_rst_midflight();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s_to_u_pipe.md
# s_to_u_pipe

Parametrised, pipelined signed-to-sign/magnitude converter for the FPU add/sub datapath. Converts a FRAC_W-bit two's-complement fraction into a sign bit and a (FRAC_W-1)-bit magnitude, with three modes: plain magnitude, exponent-determine realignment, and normalise. It also reports leading-zero count, zero and overflow flags. It sits between the fraction adder and the rounding/exponent-adjust stage, with valid/ready handshakes on both sides.

## Interface
- FRAC_W, 27, signed input width (≥4); magnitude width MAG_W = FRAC_W-1
- TAG_W, 4, width of the opaque sideband tag carried with each item
- LZC_W, derived $clog2(FRAC_W), leading-zero count width (not overridable)
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  input item present
- in_ready  out  1  block accepts item this cycle
- in_frac  in  FRAC_W  signed fraction
- in_mode  in  2  0=MAG, 1=SHIFT, 2=NORM, 3=reserved (treated as MAG)
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sign  out  1  sign of result
- out_mag  out  MAG_W  magnitude (normalised in NORM mode)
- out_lzc  out  LZC_W  leading zeros of pre-normalise magnitude
- out_zero  out  1  magnitude is zero
- out_ovf  out  1  MAG/NORM input was most-negative value
- out_tag  out  TAG_W  tag of this item

## Operation
- Stage A (on accept): compute sign and pre-magnitude m.
  - MAG/NORM: sign = in_frac[FRAC_W-1]; m = sign ? -in_frac : in_frac, truncated to MAG_W bits.
  - In MAG/NORM, if in_frac = 1 followed by all zeros, then m = all ones and ovf = 1 (saturate, never wrap to 0).
  - SHIFT: sign = in_frac[FRAC_W-1]; m = {in_frac[FRAC_W-3:0], 1'b0}; ovf = 0; no negation.
- Stage B: lzc = leading zeros of m. m = 0 gives lzc = MAG_W and zero = 1.
  - NORM: out_mag = m << lzc.
  - Other modes: out_mag = m.
  - zero and lzc are reported in every mode.
- Mode and tag travel with the item through both stages.
- flush: clears both stage valids next edge. A simultaneous in_valid & in_ready transfer is discarded.

## Timing
- Latency 2 cycles accept-to-out_valid; throughput 1 item/cycle when out_ready held high.
- Per-stage ready: rdyB = !vB | out_ready; rdyA = !vA | rdyB; in_ready = rdyA.
  - in_ready is combinational from out_ready; this path is allowed.
- Stalled stage holds data and valid unchanged. out_* stable while out_valid & !out_ready.
- Accept on in_valid & in_ready; deliver on out_valid & out_ready. No loss, no duplication, order preserved.
- Simultaneous deliver and accept on a full pipe: all stages advance in the same cycle.
- RST: vA = vB = 0; all data regs 0; outputs out_valid = 0, out_sign = 0, out_mag = 0, out_lzc = 0, out_zero = 0, out_ovf = 0, out_tag = 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation drops all in-flight items.
- flush asserted with RST: RST dominates.

## Structure
- Shared FPU package gets:
  - mode enum `s2u_mode_t` (MAG, SHIFT, NORM, RSVD)
  - default FRAC_W constant
  - helper function for most-negative detection
- One sub-module, `lzc_pow2`: parametrised combinational leading-zero counter, MAG_W in, LZC_W out, zero flag.
- Top holds two register stages, handshake logic and the normalise shifter.

## Test plan
- MAG, in_frac = 27'h7FFFFFB (−5) → sign 1, mag 26'd5, lzc 23, zero 0, ovf 0, out_valid 2 cycles after accept.
- NORM, 27'h7FFFFFB → sign 1, mag 26'h2800000, lzc 23; NORM of 27'h0 → mag 0, lzc 26, zero 1.
- MAG, 27'h4000000 → sign 1, mag 26'h3FFFFFF, ovf 1; SHIFT, 27'h5555555 → sign 1, mag 26'h2AAAAAA, ovf 0.
- Back-to-back 8 items, out_ready low cycles 3–5 → in_ready low after 2 items buffered, all 8 delivered in order with matching tags, out_* stable while stalled.
- RST pulse with 2 items in flight → out_valid 0 immediately (async), in_ready 1, no stale item delivered after release.
- flush with full pipe plus concurrent input → next cycle out_valid 0, none of the 3 items emerge.
